// File: rtl/vga_framebuffer_reader_pkg.sv
// Shared SRAM bus types, frame reader FSM states and VGA frame geometry
// for the framebuffer scan-out path.
package vga_framebuffer_reader_pkg;

  localparam int SRAM_ADDR_BITS   = 20;
  localparam int SRAM_DATA_BITS   = 16;
  localparam int VGA_H_PIXELS     = 800;
  localparam int VGA_V_LINES      = 600;
  localparam int VGA_FRAME_PIXELS = VGA_H_PIXELS * VGA_V_LINES;

  typedef logic [SRAM_ADDR_BITS-1:0] SramAddress_t;
  typedef logic [SRAM_DATA_BITS-1:0] SramData_t;

  typedef struct packed {
    logic         oe_n;
    logic         we_n;
    logic         den;
    SramAddress_t address;
    SramData_t    dout;
  } SramRequest_t;

  typedef struct packed {
    SramData_t din;
  } SramResult_t;

  typedef enum logic [1:0] {IDLE, FETCH, DONE} FrameReaderState;

endpackage

// File: rtl/vga_framebuffer_reader_fifo.sv
// Synchronous prefetch FIFO for scan-out pixels; pointers carry one extra
// wrap bit so full/empty come from an MSB compare.
module pixel_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        dout,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic [WIDTH-1:0] lastPopped;
  logic             doPush;
  logic             doPop;

  assign empty  = (wrPtr == rdPtr);
  assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign count  = wrPtr - rdPtr;
  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  // An empty FIFO keeps presenting the last pixel handed out rather than stale RAM.
  assign dout = empty ? lastPopped : mem[rdPtr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      lastPopped <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (doPop) begin
        rdPtr      <= rdPtr + 1'b1;
        lastPopped <= mem[rdPtr[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/vga_framebuffer_reader.sv
// Framebuffer scan-out: fetches one frame from SRAM in raster order into a
// prefetch FIFO. Define FB_DOUBLE_BUFFER_EN to latch the base address per frame.
module vga_framebuffer_reader
  import vga_framebuffer_reader_pkg::*;
#(
  parameter int FRAME_PIXELS = VGA_FRAME_PIXELS,
  parameter int FIFO_DEPTH   = 16,
  parameter int PIXEL_BITS   = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frameStart,
  input  logic                  pixelRd,
  output logic [PIXEL_BITS-1:0] pixelData,
  output logic                  pixelValid,
  output logic                  underrun,
  output logic                  paintDone,
  input  SramAddress_t          vgaBaseAddress,
  input  logic                  ramGrant,
  output SramRequest_t          ramRequest,
  input  SramResult_t           ramResult
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam SramAddress_t LAST_OFFSET = SramAddress_t'(FRAME_PIXELS - 1);

  FrameReaderState state;
  FrameReaderState stateNext;
  SramAddress_t    offset;
  SramAddress_t    base;
  logic            inFlight;
  logic            inFlightLast;
  logic [CW-1:0]   fifoCount;
  logic            fifoFull;
  logic            fifoEmpty;
  logic [CW:0]     credit;
  logic            canIssue;
  logic            issue;
  logic            lastIssue;
  logic            pushWord;
  logic            unusedBits;

`ifdef FB_DOUBLE_BUFFER_EN
  SramAddress_t baseReg;

  always_ff @(posedge clk) begin
    if (rst) begin
      baseReg <= '0;
    end else if (frameStart) begin
      baseReg <= vgaBaseAddress;
    end
  end

  assign base = baseReg;
`else
  assign base = vgaBaseAddress;
`endif

  // Occupancy plus the outstanding read must stay below depth so data never lands in a full FIFO.
  assign credit    = {1'b0, fifoCount} + {{CW{1'b0}}, inFlight};
  assign canIssue  = (state == FETCH) && !frameStart && (credit < (CW+1)'(FIFO_DEPTH));
  assign issue     = canIssue && ramGrant;
  assign lastIssue = issue && (offset == LAST_OFFSET);
  assign pushWord  = inFlight && !frameStart;
  assign unusedBits = ^{ramResult.din, fifoFull};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    if (frameStart) begin
      stateNext = FETCH;
    end else if (lastIssue) begin
      stateNext = DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || frameStart) begin
      offset       <= '0;
      inFlight     <= 1'b0;
      inFlightLast <= 1'b0;
    end else begin
      inFlight     <= issue;
      inFlightLast <= lastIssue;
      if (issue) begin
        offset <= offset + SramAddress_t'(1);
      end
    end
  end

  always_comb begin
    ramRequest      = '0;
    ramRequest.oe_n = !issue;
    ramRequest.we_n = 1'b1;
    if (state != IDLE) begin
      ramRequest.address = base + offset;
    end
    paintDone = inFlight && inFlightLast && !frameStart;
    underrun  = pixelRd && fifoEmpty;
  end

  assign pixelValid = !fifoEmpty;

  pixel_fifo #(
    .WIDTH (PIXEL_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (frameStart),
    .push  (pushWord),
    .pop   (pixelRd),
    .din   (ramResult.din[PIXEL_BITS-1:0]),
    .dout  (pixelData),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifoCount)
  );

endmodule

// File: tb/tb_vga_framebuffer_reader.sv
// Scoreboard bench for vga_framebuffer_reader with a small frame and a
// behavioural one-cycle-latency SRAM.
module tb_vga_framebuffer_reader;
  import vga_framebuffer_reader_pkg::*;

  localparam int FP = 32;
  localparam int FD = 16;
  localparam int PB = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          frameStart;
  logic          pixelRd;
  logic [PB-1:0] pixelData;
  logic          pixelValid;
  logic          underrun;
  logic          paintDone;
  SramAddress_t  vgaBaseAddress;
  logic          ramGrant;
  SramRequest_t  ramRequest;
  SramResult_t   ramResult;

  int total = 0;
  int bad = 0;
  int readCount = 0;
  int doneCount = 0;
  logic [PB-1:0] lastPix = '0;
  SramAddress_t  expAddr[$];
  logic [PB-1:0] expPix[$];

  logic          sOe;
  SramAddress_t  sAddr;
  logic          sValid;
  logic [PB-1:0] sData;
  logic          sUnder;
  logic          sDone;

  always #5 clk = ~clk;

  vga_framebuffer_reader #(
    .FRAME_PIXELS (FP),
    .FIFO_DEPTH   (FD),
    .PIXEL_BITS   (PB)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .frameStart     (frameStart),
    .pixelRd        (pixelRd),
    .pixelData      (pixelData),
    .pixelValid     (pixelValid),
    .underrun       (underrun),
    .paintDone      (paintDone),
    .vgaBaseAddress (vgaBaseAddress),
    .ramGrant       (ramGrant),
    .ramRequest     (ramRequest),
    .ramResult      (ramResult)
  );

  function automatic SramData_t sramWord(input SramAddress_t a);
    return (a[15:0] * 16'd37 + 16'd11) ^ 16'h5A3C;
  endfunction

  always @(posedge clk) begin
    ramResult.din <= (!ramRequest.oe_n && ramGrant) ? sramWord(ramRequest.address) : 16'hBEEF;
  end

  task automatic loadFrame(input SramAddress_t b);
    SramData_t w;
    expAddr.delete();
    expPix.delete();
    for (int i = 0; i < FP; i++) begin
      expAddr.push_back(b + SramAddress_t'(i));
      w = sramWord(b + SramAddress_t'(i));
      expPix.push_back(w[PB-1:0]);
    end
    readCount = 0;
    doneCount = 0;
  endtask

  // One clock cycle: drive inputs, sample outputs, settle the scoreboard.
  task automatic step(input logic g, input logic rd, input logic fs);
    SramAddress_t ea;
    logic [PB-1:0] ep;
    @(posedge clk);
    #1;
    ramGrant = g;
    pixelRd = rd;
    frameStart = fs;
    #1;
    sOe = ramRequest.oe_n;
    sAddr = ramRequest.address;
    sValid = pixelValid;
    sData = pixelData;
    sUnder = underrun;
    sDone = paintDone;
    total++;
    if (ramRequest.we_n !== 1'b1 || ramRequest.den !== 1'b0 || ramRequest.dout !== '0) begin
      bad++;
      $display("FAIL bus_readonly: we_n=%b den=%b dout=%h want 1/0/0", ramRequest.we_n, ramRequest.den, ramRequest.dout);
    end
    if (sOe === 1'b0) begin
      readCount++;
      total++;
      if (!g) begin
        bad++;
        $display("FAIL read_without_grant: oe_n=0 addr=%h want oe_n=1", sAddr);
      end else if (expAddr.size() == 0) begin
        bad++;
        $display("FAIL extra_read: addr=%h want no read", sAddr);
      end else begin
        ea = expAddr.pop_front();
        if (sAddr !== ea) begin
          bad++;
          $display("FAIL read_addr: got %h want %h", sAddr, ea);
        end
      end
    end
    if (rd && sValid === 1'b1 && !fs) begin
      total++;
      if (expPix.size() == 0) begin
        bad++;
        $display("FAIL extra_pixel: got %h want none", sData);
      end else begin
        ep = expPix.pop_front();
        lastPix = ep;
        if (sData !== ep) begin
          bad++;
          $display("FAIL pixel_data: got %h want %h", sData, ep);
        end
      end
    end
    if (sDone === 1'b1) doneCount++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    vgaBaseAddress = 20'h00100;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    total++;
    if (sOe !== 1'b1 || sAddr !== '0 || sValid !== 1'b0 || sData !== '0 || sDone !== 1'b0 || sUnder !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: oe_n=%b addr=%h valid=%b data=%h done=%b under=%b want 1/0/0/0/0/0",
               sOe, sAddr, sValid, sData, sDone, sUnder);
    end
    rst = 1'b0;
    readCount = 0;
    doneCount = 0;
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0);
    total++;
    if (readCount != 0 || doneCount != 0 || sValid !== 1'b0 || sOe !== 1'b1) begin
      bad++;
      $display("FAIL idle_quiet: reads=%0d dones=%0d valid=%b oe_n=%b want 0/0/0/1", readCount, doneCount, sValid, sOe);
    end
    total++;
    if (dut.state !== IDLE) begin
      bad++;
      $display("FAIL idle_state: got %0d want %0d", dut.state, IDLE);
    end
  endtask

  task automatic test_fill();
    vgaBaseAddress = 20'h00100;
    loadFrame(20'h00100);
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'b0);
    total++;
    if (readCount != FD || expAddr.size() != FP - FD) begin
      bad++;
      $display("FAIL fill_reads: got %0d reads want %0d", readCount, FD);
    end
    total++;
    if (sOe !== 1'b1 || sValid !== 1'b1 || doneCount != 0) begin
      bad++;
      $display("FAIL fill_stall: oe_n=%b valid=%b dones=%0d want 1/1/0", sOe, sValid, doneCount);
    end
  endtask

  task automatic test_drain();
    for (int c = 0; c < 200 && expPix.size() > 0; c++) step(1'b1, 1'b1, 1'b0);
    total++;
    if (expPix.size() != 0 || expAddr.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: pixels left %0d addrs left %0d want 0/0", expPix.size(), expAddr.size());
    end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    total++;
    if (doneCount != 1) begin
      bad++;
      $display("FAIL paint_done_count: got %0d want 1", doneCount);
    end
    total++;
    if (sUnder !== 1'b1 || sData !== lastPix || sOe !== 1'b1) begin
      bad++;
      $display("FAIL drained_hold: under=%b data=%h oe_n=%b want 1/%h/1", sUnder, sData, sOe, lastPix);
    end
    total++;
    if (dut.state !== DONE) begin
      bad++;
      $display("FAIL done_state: got %0d want %0d", dut.state, DONE);
    end
  endtask

  task automatic test_grant_toggle();
    vgaBaseAddress = 20'h00240;
    loadFrame(20'h00240);
    step(1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 300 && expPix.size() > 0; c++) step((c % 2) == 0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    total++;
    if (readCount != FP || expAddr.size() != 0 || expPix.size() != 0) begin
      bad++;
      $display("FAIL toggle_reads: got %0d reads want %0d", readCount, FP);
    end
    total++;
    if (doneCount != 1) begin
      bad++;
      $display("FAIL toggle_done: got %0d want 1", doneCount);
    end
  endtask

  task automatic test_underrun();
    vgaBaseAddress = 20'h00300;
    loadFrame(20'h00300);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    total++;
    if (sUnder !== 1'b1 || sValid !== 1'b0) begin
      bad++;
      $display("FAIL underrun_pulse: under=%b valid=%b want 1/0", sUnder, sValid);
    end
    total++;
    if ((^sData) === 1'bx || sData !== lastPix) begin
      bad++;
      $display("FAIL underrun_data: got %h want %h", sData, lastPix);
    end
    step(1'b0, 1'b0, 1'b0);
    total++;
    if (sUnder !== 1'b0) begin
      bad++;
      $display("FAIL underrun_clear: got %b want 0", sUnder);
    end
  endtask

  task automatic test_midframe_flush();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);
    total++;
    if (readCount != 8 || sValid !== 1'b1) begin
      bad++;
      $display("FAIL partial_fill: reads=%0d valid=%b want 8/1", readCount, sValid);
    end
`ifdef FB_DOUBLE_BUFFER_EN
    vgaBaseAddress = 20'h00480;
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0);
    total++;
    if (readCount != 10) begin
      bad++;
      $display("FAIL latched_base: reads=%0d want 10", readCount);
    end
`endif
    vgaBaseAddress = 20'h00500;
    loadFrame(20'h00500);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    total++;
    if (sValid !== 1'b0) begin
      bad++;
      $display("FAIL flush_empty: valid=%b want 0", sValid);
    end
    step(1'b1, 1'b0, 1'b0);
    total++;
    if (sOe !== 1'b0 || sAddr !== 20'h00500) begin
      bad++;
      $display("FAIL restart_addr: oe_n=%b addr=%h want 0/00500", sOe, sAddr);
    end
    for (int c = 0; c < 200 && expPix.size() > 0; c++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    total++;
    if (expPix.size() != 0 || doneCount != 1) begin
      bad++;
      $display("FAIL flush_frame: pixels left %0d dones %0d want 0/1", expPix.size(), doneCount);
    end
  endtask

  task automatic test_back_to_back();
    bit seenLast = 1'b0;
    vgaBaseAddress = 20'h00600;
    loadFrame(20'h00600);
    step(1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 200 && !seenLast; c++) begin
      step(1'b1, 1'b1, 1'b0);
      if (sOe === 1'b0 && sAddr === 20'h0061F) seenLast = 1'b1;
    end
    total++;
    if (!seenLast) begin
      bad++;
      $display("FAIL last_read_timeout: seen=%b want 1", seenLast);
    end
    vgaBaseAddress = 20'h00700;
    step(1'b0, 1'b0, 1'b1);
    total++;
    if (sDone !== 1'b0 || doneCount != 0) begin
      bad++;
      $display("FAIL done_suppressed: done=%b count=%0d want 0/0", sDone, doneCount);
    end
    loadFrame(20'h00700);
    step(1'b0, 1'b0, 1'b0);
    total++;
    if (sValid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_flush: valid=%b want 0", sValid);
    end
    for (int c = 0; c < 200 && expPix.size() > 0; c++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    total++;
    if (expPix.size() != 0 || readCount != FP || doneCount != 1) begin
      bad++;
      $display("FAIL b2b_frame: left %0d reads %0d dones %0d want 0/%0d/1", expPix.size(), readCount, doneCount, FP);
    end
  endtask

  initial begin
    rst = 1'b1;
    frameStart = 1'b0;
    pixelRd = 1'b0;
    ramGrant = 1'b0;
    vgaBaseAddress = '0;
    test_reset();
    test_fill();
    test_drain();
    test_grant_toggle();
    test_underrun();
    test_midframe_flush();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
